// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encodings, the NOP
// word shown to decode when nothing is queued, and queue sizing helpers.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    // Occupancy counters need one extra bit so that "full" is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_instr_queue.sv
// Small synchronous FIFO of {instruction, pc} entries with a combinational
// head; flush wins over a same-cycle push.
module fetch_instr_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH = 62,
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = count_width(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;

    always_comb begin
        count_next = count_reg;
        if (i_push && !i_pop) begin
            count_next = count_reg + CW'(1);
        end else if (i_pop && !i_push) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Entries are not reset; the count alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush && !i_rst) begin
            mem_reg[wr_ptr_reg] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (i_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (i_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_next;
        end
    end

    assign o_head  = mem_reg[rd_ptr_reg];
    assign o_count = count_reg;

endmodule

// File: rtl/fetch.sv
// MIPS instruction fetch: issues word-addressed requests over req/ack, queues
// returned instructions for decode and handles redirects and stalls.
module fetch
    import fetch_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH    = 30,
    parameter int QUEUE_DEPTH = 2,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    output logic                   o_imem_req,
    output logic [PC_WIDTH-1:0]    o_imem_addr,
    input  logic                   i_imem_ack,
    input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
    output logic [INSTR_WIDTH-1:0] o_instruction,
    output logic [PC_WIDTH-1:0]    o_pc_fe,
    output logic [PC_WIDTH-1:0]    o_inc_pc,
    output logic                   o_valid,
    input  logic                   i_stall_en,
    input  logic                   i_hazard_stall,
    input  logic                   i_jmp_en,
    input  logic [PC_WIDTH-1:0]    i_pc_jmp
);

    localparam int CW = count_width(QUEUE_DEPTH);
    localparam int QW = INSTR_WIDTH + PC_WIDTH;
    localparam logic [CW-1:0] DEPTH_C    = CW'(QUEUE_DEPTH);
    localparam logic [CW-1:0] DEPTH_M1_C = CW'(QUEUE_DEPTH - 1);

    fetch_state_t         state_reg;
    logic                 req_reg;
    logic [PC_WIDTH-1:0]  addr_reg;
    logic [PC_WIDTH-1:0]  fetch_pc_reg;
    logic [PC_WIDTH-1:0]  deliver_pc_reg;

    logic [CW-1:0]        q_count;
    logic [QW-1:0]        q_head;
    logic [INSTR_WIDTH-1:0] head_instr;
    logic [PC_WIDTH-1:0]  head_pc;
    logic                 pop;
    logic                 push;
    logic [CW-1:0]        occ_after_pop;
    logic                 space;
    logic                 space_after_push;

    assign o_valid    = (q_count != '0);
    assign pop        = o_valid && !i_stall_en && !i_hazard_stall && !i_jmp_en;
    assign push       = (state_reg == ST_REQ) && i_imem_ack && !i_jmp_en;

    assign occ_after_pop    = q_count - CW'(pop);
    assign space            = occ_after_pop < DEPTH_C;
    assign space_after_push = occ_after_pop < DEPTH_M1_C;

    fetch_instr_queue #(
        .WIDTH (QW),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (push),
        .i_push_data ({i_imem_rdata, fetch_pc_reg}),
        .i_pop       (pop),
        .i_flush     (i_jmp_en),
        .o_head      (q_head),
        .o_count     (q_count)
    );

    assign head_instr = q_head[QW-1:PC_WIDTH];
    assign head_pc    = q_head[PC_WIDTH-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= ST_IDLE;
            req_reg        <= 1'b0;
            addr_reg       <= RESET_PC;
            fetch_pc_reg   <= RESET_PC;
            deliver_pc_reg <= RESET_PC;
        end else if (i_jmp_en) begin
            fetch_pc_reg   <= i_pc_jmp;
            deliver_pc_reg <= i_pc_jmp;
            case (state_reg)
                ST_IDLE: begin
                    state_reg <= ST_REQ;
                    req_reg   <= 1'b1;
                    addr_reg  <= i_pc_jmp;
                end
                ST_REQ: begin
                    // Without an ack the old request is still live at the
                    // memory, so its address must stay put until it returns.
                    if (i_imem_ack) begin
                        state_reg <= ST_REQ;
                        addr_reg  <= i_pc_jmp;
                    end else begin
                        state_reg <= ST_DROP;
                    end
                    req_reg <= 1'b1;
                end
                ST_DROP: begin
                    state_reg <= ST_DROP;
                    req_reg   <= 1'b1;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    req_reg   <= 1'b0;
                end
            endcase
        end else begin
            if (pop) begin
                deliver_pc_reg <= deliver_pc_reg + PC_WIDTH'(1);
            end
            case (state_reg)
                ST_IDLE: begin
                    if (space) begin
                        state_reg <= ST_REQ;
                        req_reg   <= 1'b1;
                        addr_reg  <= fetch_pc_reg;
                    end
                end
                ST_REQ: begin
                    if (i_imem_ack) begin
                        fetch_pc_reg <= fetch_pc_reg + PC_WIDTH'(1);
                        if (space_after_push) begin
                            addr_reg <= fetch_pc_reg + PC_WIDTH'(1);
                        end else begin
                            state_reg <= ST_IDLE;
                            req_reg   <= 1'b0;
                        end
                    end
                end
                ST_DROP: begin
                    if (i_imem_ack) begin
                        if (space) begin
                            state_reg <= ST_REQ;
                            req_reg   <= 1'b1;
                            addr_reg  <= fetch_pc_reg;
                        end else begin
                            state_reg <= ST_IDLE;
                            req_reg   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_req    = req_reg;
    assign o_imem_addr   = addr_reg;
    assign o_instruction = o_valid ? head_instr : INSTR_WIDTH'(NOP_INSTR);
    assign o_pc_fe       = o_valid ? head_pc : deliver_pc_reg;
    assign o_inc_pc      = o_pc_fe + PC_WIDTH'(1);

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: a latency-programmable memory model answers requests with
// {2'b10, addr}; a monitor checks every instruction decode consumes.
module tb_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [29:0] pc_fe;
    logic [29:0] inc_pc;
    logic        valid;
    logic        stall_en;
    logic        hazard;
    logic        jmp;
    logic [29:0] pc_jmp;

    int mem_lat;
    int wait_cnt;
    int errors = 0;
    int checks = 0;
    logic [29:0] exp_q[$];
    logic [29:0] mon_pc;

    fetch #(
        .INSTR_WIDTH (32),
        .PC_WIDTH    (30),
        .QUEUE_DEPTH (2),
        .RESET_PC    (30'h0)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .o_imem_req     (imem_req),
        .o_imem_addr    (imem_addr),
        .i_imem_ack     (imem_ack),
        .i_imem_rdata   (imem_rdata),
        .o_instruction  (instruction),
        .o_pc_fe        (pc_fe),
        .o_inc_pc       (inc_pc),
        .o_valid        (valid),
        .i_stall_en     (stall_en),
        .i_hazard_stall (hazard),
        .i_jmp_en       (jmp),
        .i_pc_jmp       (pc_jmp)
    );

    // Memory model: ack after mem_lat wait cycles of a held request.
    assign imem_ack   = imem_req && (wait_cnt >= mem_lat);
    assign imem_rdata = {2'b10, imem_addr};

    always @(posedge clk) begin
        if (rst || !imem_req || imem_ack) wait_cnt <= 0;
        else                              wait_cnt <= wait_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int bound);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            tick();
            if (exp_q.size() == 0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic expect_run(input logic [29:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 30'(i));
    endtask

    // Monitor: whatever decode consumes must be the next expected entry.
    always @(negedge clk) begin
        if (!rst && valid && !stall_en && !hazard && !jmp) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery: got pc=%h required none", pc_fe);
            end else begin
                mon_pc = exp_q.pop_front();
                $display("deliver pc=%h instr=%h inc=%h", pc_fe, instruction, inc_pc);
                chk("deliver_instr", instruction, {2'b10, mon_pc});
                chk("deliver_pc", {2'b00, pc_fe}, {2'b00, mon_pc});
                chk("deliver_inc_pc", {2'b00, inc_pc}, {2'b00, mon_pc + 30'd1});
            end
        end
    end

    initial begin
        rst = 1'b1; stall_en = 1'b0; hazard = 1'b1; jmp = 1'b0; pc_jmp = '0;
        mem_lat = 0;
        tick(); tick();

        // Reset state
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_pc_fe", {2'b00, pc_fe}, 32'h0);
        chk("rst_inc_pc", {2'b00, inc_pc}, 32'h1);

        // Back-to-back zero-wait fetch from 0
        rst = 1'b0;
        expect_run(30'd0, 5);
        hazard = 1'b0;
        wait_drain(40);

        // Hazard stall with pc 5 at the head: queue fills, requests stop
        hazard = 1'b1;
        tick(); tick();
        chk("hz_req_off", {31'b0, imem_req}, 32'd0);
        chk("hz_valid", {31'b0, valid}, 32'd1);
        chk("hz_pc_fe", {2'b00, pc_fe}, 32'd5);
        chk("hz_instr", instruction, {2'b10, 30'd5});
        tick();
        chk("hz_hold_pc_fe", {2'b00, pc_fe}, 32'd5);
        chk("hz_hold_req", {31'b0, imem_req}, 32'd0);
        expect_run(30'd5, 5);
        hazard = 1'b0;
        wait_drain(40);
        hazard = 1'b1;
        repeat (4) tick();

        // Slow memory: redirect on the first wait cycle of an outstanding request
        mem_lat = 3;
        jmp = 1'b1; pc_jmp = 30'h40;
        tick();
        pc_jmp = 30'h100;
        tick();
        jmp = 1'b0;
        chk("drop_req", {31'b0, imem_req}, 32'd1);
        chk("drop_addr0", {2'b00, imem_addr}, 32'h40);
        chk("drop_valid", {31'b0, valid}, 32'd0);
        chk("drop_pc_fe", {2'b00, pc_fe}, 32'h100);
        tick();
        chk("drop_addr1", {2'b00, imem_addr}, 32'h40);
        tick();
        chk("drop_addr2", {2'b00, imem_addr}, 32'h40);
        tick();
        chk("drop_next_req", {31'b0, imem_req}, 32'd1);
        chk("drop_next_addr", {2'b00, imem_addr}, 32'h100);
        chk("drop_next_valid", {31'b0, valid}, 32'd0);
        expect_run(30'h100, 4);
        hazard = 1'b0;
        wait_drain(100);
        hazard = 1'b1;
        repeat (20) tick();
        chk("full_req_off", {31'b0, imem_req}, 32'd0);
        chk("full_pc_fe", {2'b00, pc_fe}, 32'h104);

        // Redirect coinciding with an ack and a would-be pop
        mem_lat = 0;
        expect_run(30'h104, 1);
        hazard = 1'b0;
        tick();
        chk("co_req", {31'b0, imem_req}, 32'd1);
        chk("co_addr", {2'b00, imem_addr}, 32'h106);
        chk("co_head", {2'b00, pc_fe}, 32'h105);
        jmp = 1'b1; pc_jmp = 30'h200;
        tick();
        jmp = 1'b0; hazard = 1'b1;
        chk("co_flush_valid", {31'b0, valid}, 32'd0);
        chk("co_new_req", {31'b0, imem_req}, 32'd1);
        chk("co_new_addr", {2'b00, imem_addr}, 32'h200);
        chk("co_pc_fe", {2'b00, pc_fe}, 32'h200);
        expect_run(30'h200, 3);
        hazard = 1'b0;
        wait_drain(40);
        hazard = 1'b1;
        repeat (4) tick();

        // PC wrap at the top of the address space, held by an execute stall
        hazard = 1'b0; stall_en = 1'b1;
        jmp = 1'b1; pc_jmp = 30'h3FFF_FFFF;
        tick();
        jmp = 1'b0;
        tick();
        chk("wrap_head_pc", {2'b00, pc_fe}, 32'h3FFF_FFFF);
        chk("wrap_instr", instruction, 32'hBFFF_FFFF);
        chk("wrap_inc_pc", {2'b00, inc_pc}, 32'h0);
        chk("wrap_next_addr", {2'b00, imem_addr}, 32'h0);
        expect_run(30'h3FFF_FFFF, 3);
        stall_en = 1'b0;
        wait_drain(40);
        hazard = 1'b1;
        repeat (4) tick();

        // Reset while dropping a stale response
        mem_lat = 3;
        jmp = 1'b1; pc_jmp = 30'h10;
        tick();
        pc_jmp = 30'h20;
        tick();
        jmp = 1'b0;
        chk("rd_in_drop_addr", {2'b00, imem_addr}, 32'h10);
        rst = 1'b1;
        tick();
        chk("rd_req", {31'b0, imem_req}, 32'd0);
        chk("rd_valid", {31'b0, valid}, 32'd0);
        chk("rd_instr", instruction, 32'h0);
        chk("rd_pc_fe", {2'b00, pc_fe}, 32'h0);
        rst = 1'b0; mem_lat = 0;
        expect_run(30'd0, 3);
        hazard = 1'b0;
        wait_drain(40);
        hazard = 1'b1;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
